// File: rtl/plab2_proc_mem_responder.sv
// Word-addressed memory responder: one val/rdy request in flight, response after p_latency cycles.
// Optional PLAB2_PROC_MEM_RESPONDER_DOMAIN_PART_EN splits storage into two sd-selected halves.
module plab2_proc_mem_responder #(
   parameter int unsigned p_mem_nwords = 256,
   parameter int unsigned p_latency    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memreq_val,
   output logic        memreq_rdy,
   input  logic        memreq_msg_type,
   input  logic [31:0] memreq_msg_addr,
   input  logic [31:0] memreq_msg_data,
   output logic        memresp_val,
   input  logic        memresp_rdy,
   output logic        memresp_msg_type,
   output logic [31:0] memresp_msg_data,
   input  logic        sd
);

   localparam int unsigned AW = $clog2(p_mem_nwords);
   localparam int unsigned LatInitInt = (p_latency >= 2) ? (p_latency - 2) : 0;
   localparam logic [3:0]  LatInit = LatInitInt[3:0];

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          type_q, type_d;
   logic [31:0]   data_q, data_d;
   logic [31:0]   mem_q [p_mem_nwords];
   logic [AW-1:0] idx;
   logic          accept;
   logic          unused_in;

`ifdef PLAB2_PROC_MEM_RESPONDER_DOMAIN_PART_EN
   // sd replaces the index MSB, so each domain only sees its own half.
   assign idx       = {sd, memreq_msg_addr[AW:2]};
   assign unused_in = ^{memreq_msg_addr[31:AW+1], memreq_msg_addr[1:0]};
`else
   assign idx       = memreq_msg_addr[AW+1:2];
   assign unused_in = ^{memreq_msg_addr[31:AW+2], memreq_msg_addr[1:0], sd};
`endif

   assign accept = (state_q == StIdle) && memreq_val;

   always_ff @(posedge clk) begin
      if (accept && memreq_msg_type && !reset) begin
         mem_q[idx] <= memreq_msg_data;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      type_d  = type_q;
      data_d  = data_q;
      unique case (state_q)
         StIdle: begin
            if (memreq_val) begin
               type_d = memreq_msg_type;
               data_d = memreq_msg_type ? 32'h0 : mem_q[idx];
               if (p_latency == 1) begin
                  state_d = StResp;
               end else begin
                  state_d = StWait;
                  cnt_d   = LatInit;
               end
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) begin
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (memresp_rdy) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         type_q  <= 1'b0;
         data_q  <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         data_q  <= data_d;
      end
   end

   assign memreq_rdy       = (state_q == StIdle);
   assign memresp_val      = (state_q == StResp);
   assign memresp_msg_type = type_q;
   assign memresp_msg_data = data_q;

endmodule
